// File: rtl/guess_round_tracker.sv
// -----------------------------------------------------------------------------
// guess_round_tracker
//
// Front end of the difficulty FSM. It turns the raw confirm button into a
// single-cycle confirm pulse, scores each confirmed guess against the secret
// number, and runs the per-difficulty countdown timer. The round,
// incorrect_guesses and timer outputs are what the FSM uses for its
// difficulty, gameover and win decisions.
//
// Parameters
//   TICKS_PER_SEC  clk cycles per timer second
//   T_DIFF1        seconds loaded when difficulty 1 is entered
//   T_DIFF2        seconds loaded when difficulty 2 is entered
//   T_DIFF3        seconds loaded when difficulty 3 is entered (<= 127)
//
// Ports
//   clk                in   1   system clock
//   restart            in   1   asynchronous active-high reset
//   confirm_btn        in   1   raw confirm button level, asynchronous to clk
//   guess              in  10   player's entered number, 0..999
//   secret             in  10   target number, 0..999
//   diff_timer         in   2   active difficulty: 1/2/3 playing, 0 idle
//   confirm_pulse      out  1   one-cycle pulse per confirm press
//   round              out  3   correct guesses this difficulty, saturates at 7
//   incorrect_guesses  out  3   wrong guesses this difficulty, saturates at 7
//   timer              out  7   seconds left this difficulty, stops at 0
//   guess_correct      out  1   result of the most recent scored guess
// -----------------------------------------------------------------------------
module guess_round_tracker #(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int T_DIFF1       = 30,
   parameter int T_DIFF2       = 60,
   parameter int T_DIFF3       = 90
) (
   input  logic       clk,
   input  logic       restart,
   input  logic       confirm_btn,
   input  logic [9:0] guess,
   input  logic [9:0] secret,
   input  logic [1:0] diff_timer,
   output logic       confirm_pulse,
   output logic [2:0] round,
   output logic [2:0] incorrect_guesses,
   output logic [6:0] timer,
   output logic       guess_correct
);

   // A one-cycle second would give $clog2 == 0; keep at least one bit.
   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

   localparam logic [6:0] LOAD_D1 = 7'(T_DIFF1);
   localparam logic [6:0] LOAD_D2 = 7'(T_DIFF2);
   localparam logic [6:0] LOAD_D3 = 7'(T_DIFF3);

   // Saturating 3-bit increment: counters stop at 7 instead of wrapping.
   function automatic logic [2:0] sat_inc3(input logic [2:0] v);
      return (v == 3'd7) ? v : v + 3'd1;
   endfunction

   // Seconds loaded when a difficulty level is entered.
   function automatic logic [6:0] load_time(input logic [1:0] d);
      logic [6:0] t;
      case (d)
         2'd1:    t = LOAD_D1;
         2'd2:    t = LOAD_D2;
         2'd3:    t = LOAD_D3;
         default: t = 7'd0;
      endcase
      return t;
   endfunction

   logic          s1;
   logic          s2;
   logic          s3;
   logic [1:0]    prev_diff;
   logic [PW-1:0] prescaler;

   logic          diff_change;
   logic          playing;
   logic          time_left;
   logic          score_en;
   logic          match;

   // ---- stage: button synchronizer and edge-detect delay ----
   always_ff @(posedge clk or posedge restart) begin
      if (restart) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= confirm_btn;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // Rising edge of the synchronized level; both terms are flop outputs so
   // the pulse is glitch-free, and a held button yields a single pulse.
   assign confirm_pulse = s2 & ~s3;

   // ---- stage: decode of difficulty change and scoring qualification ----
   assign playing     = (diff_timer != 2'd0);
   assign time_left   = (timer != 7'd0);
   assign diff_change = (diff_timer != prev_diff) && playing;
   // A difficulty change wins over a coincident press; that press is dropped.
   assign score_en    = confirm_pulse && playing && time_left && !diff_change;
   assign match       = (guess == secret);

   // ---- stage: registered counters, timer and result ----
   always_ff @(posedge clk or posedge restart) begin
      if (restart) begin
         prev_diff         <= 2'd0;
         prescaler         <= '0;
         timer             <= 7'd0;
         round             <= 3'd0;
         incorrect_guesses <= 3'd0;
         guess_correct     <= 1'b0;
      end else begin
         prev_diff <= diff_timer;

         if (diff_change) begin
            round             <= 3'd0;
            incorrect_guesses <= 3'd0;
            guess_correct     <= 1'b0;
            timer             <= load_time(diff_timer);
            prescaler         <= '0;
         end else begin
            if (score_en) begin
               if (match) begin
                  round         <= sat_inc3(round);
                  guess_correct <= 1'b1;
               end else begin
                  incorrect_guesses <= sat_inc3(incorrect_guesses);
                  guess_correct     <= 1'b0;
               end
            end

            // Countdown runs only while playing with time left; at zero the
            // prescaler is left at 0 (it wrapped to 0 on the final second).
            if (playing && time_left) begin
               if (prescaler == PRESC_LAST) begin
                  prescaler <= '0;
                  timer     <= timer - 7'd1;
               end else begin
                  prescaler <= prescaler + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_guess_round_tracker.sv
module tb_guess_round_tracker;

   logic       clk = 1'b0;
   logic       restart;
   logic       confirm_btn;
   logic [9:0] guess;
   logic [9:0] secret;
   logic [1:0] diff_timer;
   logic       confirm_pulse;
   logic [2:0] round;
   logic [2:0] incorrect_guesses;
   logic [6:0] timer;
   logic       guess_correct;

   int checks = 0;
   int errors = 0;
   int pulses;

   guess_round_tracker #(
      .TICKS_PER_SEC(4),
      .T_DIFF1(30),
      .T_DIFF2(60),
      .T_DIFF3(90)
   ) dut (
      .clk(clk),
      .restart(restart),
      .confirm_btn(confirm_btn),
      .guess(guess),
      .secret(secret),
      .diff_timer(diff_timer),
      .confirm_pulse(confirm_pulse),
      .round(round),
      .incorrect_guesses(incorrect_guesses),
      .timer(timer),
      .guess_correct(guess_correct)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_counts(input string tag, input logic [2:0] r, input logic [2:0] w,
                               input logic g);
      check({tag, "_round"}, 32'(round), 32'(r));
      check({tag, "_incorrect"}, 32'(incorrect_guesses), 32'(w));
      check({tag, "_correct"}, 32'(guess_correct), 32'(g));
   endtask

   // One press: pulse appears in the cycle after the second sampling edge,
   // result is visible one cycle later; two idle cycles let s2/s3 clear.
   task automatic press(input logic [9:0] g, input string tag);
      guess = g;
      confirm_btn = 1'b1;
      tick();
      check({tag, "_pulse_early"}, 32'(confirm_pulse), 32'd0);
      tick();
      check({tag, "_pulse"}, 32'(confirm_pulse), 32'd1);
      confirm_btn = 1'b0;
      tick();
      check({tag, "_pulse_end"}, 32'(confirm_pulse), 32'd0);
      tick();
      tick();
   endtask

   initial begin
      restart     = 1'b1;
      confirm_btn = 1'b0;
      guess       = 10'd0;
      secret      = 10'd0;
      diff_timer  = 2'd0;

      // ---- reset state, idle press ----
      tick();
      tick();
      check("rst_timer", 32'(timer), 32'd0);
      check_counts("rst", 3'd0, 3'd0, 1'b0);
      check("rst_pulse", 32'(confirm_pulse), 32'd0);
      restart = 1'b0;
      tick();
      check("idle_timer", 32'(timer), 32'd0);
      check_counts("idle", 3'd0, 3'd0, 1'b0);
      press(10'd0, "idle_press");
      check_counts("idle_after", 3'd0, 3'd0, 1'b0);
      check("idle_after_timer", 32'(timer), 32'd0);

      // ---- countdown in difficulty 1 ----
      diff_timer = 2'd1;
      tick();
      check("d1_load", 32'(timer), 32'd30);
      for (int i = 0; i < 4; i++) tick();
      check("d1_first_sec", 32'(timer), 32'd29);
      for (int i = 0; i < 115; i++) tick();
      check("d1_last_sec", 32'(timer), 32'd1);
      tick();
      check("d1_zero", 32'(timer), 32'd0);
      for (int i = 0; i < 8; i++) tick();
      check("d1_hold_zero", 32'(timer), 32'd0);

      // ---- scoring disabled at timer 0 ----
      secret = 10'd5;
      press(10'd5, "t0_press");
      check_counts("t0", 3'd0, 3'd0, 1'b0);

      // ---- re-enter difficulty 1, freeze while idle ----
      diff_timer = 2'd0;
      tick();
      diff_timer = 2'd1;
      tick();
      check("reload_timer", 32'(timer), 32'd30);
      for (int i = 0; i < 6; i++) tick();
      check("reload_sec", 32'(timer), 32'd29);
      diff_timer = 2'd0;
      for (int i = 0; i < 10; i++) tick();
      check("freeze_timer", 32'(timer), 32'd29);
      diff_timer = 2'd1;
      tick();
      check("reload2_timer", 32'(timer), 32'd30);

      // ---- correct and wrong guesses ----
      secret = 10'd7;
      for (int i = 1; i <= 5; i++) begin
         press(10'd7, "hit");
         check_counts("hit", 3'(i), 3'd0, 1'b1);
      end
      press(10'd3, "miss");
      check_counts("miss", 3'd5, 3'd1, 1'b0);
      // 10-bit equality: guess differing only in bit 9 is a miss
      press(10'h207, "miss_hi");
      check_counts("miss_hi", 3'd5, 3'd2, 1'b0);

      // ---- held button, saturation of incorrect_guesses ----
      diff_timer = 2'd0;
      tick();
      diff_timer = 2'd1;
      tick();
      check_counts("reload3", 3'd0, 3'd0, 1'b0);
      guess  = 10'd3;
      pulses = 0;
      confirm_btn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         pulses += int'(confirm_pulse);
      end
      confirm_btn = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         pulses += int'(confirm_pulse);
      end
      check("hold_one_pulse", 32'(pulses), 32'd1);
      check_counts("hold", 3'd0, 3'd1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         press(10'd3, "sat");
         check("sat_incorrect", 32'(incorrect_guesses), ((i + 2) > 7) ? 32'd7 : 32'(i + 2));
      end

      // ---- difficulty change coincident with a correct press ----
      press(10'd7, "pre_chg");
      check_counts("pre_chg", 3'd1, 3'd7, 1'b1);
      guess = 10'd7;
      confirm_btn = 1'b1;
      tick();
      tick();
      check("chg_pulse", 32'(confirm_pulse), 32'd1);
      diff_timer  = 2'd2;
      confirm_btn = 1'b0;
      tick();
      check_counts("chg", 3'd0, 3'd0, 1'b0);
      check("chg_timer", 32'(timer), 32'd60);
      tick();
      tick();
      press(10'd7, "d2_hit");
      check_counts("d2_hit", 3'd1, 3'd0, 1'b1);

      // ---- asynchronous restart mid-countdown with button held ----
      for (int i = 0; i < 3; i++) tick();
      confirm_btn = 1'b1;
      restart     = 1'b1;
      #1;
      check("async_timer", 32'(timer), 32'd0);
      check_counts("async", 3'd0, 3'd0, 1'b0);
      tick();
      tick();
      check("rst_hold_pulse", 32'(confirm_pulse), 32'd0);
      restart = 1'b0;
      tick();
      check("rel_pulse_early", 32'(confirm_pulse), 32'd0);
      tick();
      check("rel_pulse", 32'(confirm_pulse), 32'd1);
      tick();
      check("rel_pulse_end", 32'(confirm_pulse), 32'd0);
      confirm_btn = 1'b0;
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
